pixel_framebuffer_writer: RTL and testbench
===========================================

// Module: pixel_framebuffer_writer
// PURPOSE
//  Sink for the per-pixel RGB stream produced by the ray/colour pipeline (x, y, rgb, visible, valid).
//  Packs each pixel to 12-bit RGB and writes it into the back half of a double-buffered
//  framebuffer BRAM. Swaps front/back at a display vsync once a full frame has been written.
//  Sits between the pixel-colour pipeline and the video scan-out reader.
// PARAMETERS
//  H_RES     320     active pixels per line; valid x range 0..H_RES-1
//  V_RES     180     active lines per frame; valid y range 0..V_RES-1
//  BG_COLOR  12'h000 {r,g,b} written when block_visible_in=0
//  PIX_W     $clog2(H_RES*V_RES)  pixel-index width (derived, not overridden)
// PORTS
//  clk_in            in   1        system clock
//  rst_in            in   1        synchronous active-high reset
//  x_in              in   11       pixel column
//  y_in              in   11       pixel row
//  block_visible_in  in   1        1: use r/g/b_in; 0: write BG_COLOR
//  r_in,g_in,b_in    in   4 each   pixel colour
//  rgb_valid_in      in   1        pixel strobe; no backpressure, one pixel per cycle max
//  disp_vsync_in     in   1        scan-out vsync level (already in clk_in domain)
//  wr_addr_out       out  PIX_W+1  {back_buf, y*H_RES+x}
//  wr_data_out       out  12       {r,g,b}
//  wr_en_out         out  1        BRAM write enable
//  front_buf_out     out  1        buffer the scan-out reads
//  frame_done_out    out  1        1-cycle pulse on swap
//  overrun_out       out  1        sticky: pixel dropped while waiting for swap
//  drop_count_out    out  16       saturating count of dropped pixels (OOB or overrun)
// BEHAVIOUR
//  Reset: all outputs 0; front_buf=0, back_buf=1; state FILL; vsync edge detector cleared.
//  S1 (cycle 1): register pixel; in_bounds = x_in<H_RES && y_in<V_RES;
//   colour = visible ? {r,g,b} : BG_COLOR; is_last = (x==H_RES-1 && y==V_RES-1).
//  S2 (cycle 2): index = y*H_RES+x (registered; shift-add or DSP, full PIX_W, no truncation).
//   wr_en_out asserts exactly 2 cycles after rgb_valid_in when the pixel is accepted.
//  Accept = valid && in_bounds && state==FILL. Otherwise wr_en_out=0 and the pixel is dropped.
//   Any dropped valid pixel: drop_count += 1, saturating at 16'hFFFF.
//   A pixel dropped because state==WAIT_SWAP additionally sets overrun_out (sticky until rst_in).
//  FSM, evaluated at S2:
//   FILL -> WAIT_SWAP when an accepted is_last pixel is written; that write still occurs.
//   WAIT_SWAP -> FILL on a vsync rising edge (registered detect, 1 cycle).
//    That cycle: front_buf<=~front_buf, back_buf<=~back_buf, frame_done_out=1.
//  Vsync edges seen in FILL are ignored; partial frames never swap.
//  Simultaneous: is_last write and vsync edge in the same cycle -> go to WAIT_SWAP, no swap;
//   the next rising edge swaps.
//  Pixels already in S1/S2 when WAIT_SWAP is entered are dropped (overrun), never written late.
//  The first pixel accepted after a swap uses the new back_buf in wr_addr_out.
//  Duplicate or out-of-order coordinates: written as given; only is_last triggers completion.
//  rst_in mid-frame: pipeline flushed, no write occurs the next cycle, buffers return to reset assignment.
// TESTING
//  1) Reset, then stream full 320x180 raster, visible=1, rgb=5/A/3 -> 57600 writes to addr[16]=1,
//     data 12'h5A3, wr_en 2 cycles after each valid; state WAIT_SWAP; no frame_done.
//  2) After (1), pulse disp_vsync_in -> frame_done 1 cycle later, front_buf_out=1;
//     next pixel (0,0) written at addr {0,0}.
//  3) x=320,y=0 and x=0,y=180 valid -> no wr_en, drop_count=2, overrun_out stays 0.
//  4) Pixel (319,179) with visible=0 -> data=BG_COLOR, addr index 57599;
//     pixel (7,2) -> index 647.
//  5) Complete frame, keep streaming 3 pixels before vsync -> none written,
//     overrun_out=1, drop_count=3.
//  6) Vsync edge same cycle as last-pixel write -> no swap;
//     second edge swaps. Assert rst_in mid-raster -> outputs 0, front_buf=0.

Source files
------------

// File: rtl/pixel_framebuffer_writer.sv
// Per-pixel RGB sink: packs pixels to 12-bit RGB and writes them into the back half of a
// double-buffered framebuffer, swapping front/back at vsync once a complete frame is written.
module pixel_framebuffer_writer #(
   parameter int          H_RES    = 320,
   parameter int          V_RES    = 180,
   parameter logic [11:0] BG_COLOR = 12'h000,
   localparam int         PIX_W    = $clog2(H_RES * V_RES)
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [10:0]      x_in,
   input  logic [10:0]      y_in,
   input  logic             block_visible_in,
   input  logic [3:0]       r_in,
   input  logic [3:0]       g_in,
   input  logic [3:0]       b_in,
   input  logic             rgb_valid_in,
   input  logic             disp_vsync_in,
   output logic [PIX_W:0]   wr_addr_out,
   output logic [11:0]      wr_data_out,
   output logic             wr_en_out,
   output logic             front_buf_out,
   output logic             frame_done_out,
   output logic             overrun_out,
   output logic [15:0]      drop_count_out
);

   typedef enum logic {FILL, WAIT_SWAP} state_t;

   state_t           state, state_next;
   logic             s1_valid, s1_in_bounds, s1_last;
   logic [PIX_W-1:0] s1_x, s1_y;
   logic [11:0]      s1_color;
   logic             vsync_d, vsync_rise;
   logic             back_buf;
   logic             accept, drop, swap;
   logic [PIX_W-1:0] pix_index;

   // Stage 1: capture the pixel and precompute bounds, colour and end-of-frame flag
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_valid     <= 1'b0;
         s1_in_bounds <= 1'b0;
         s1_last      <= 1'b0;
         s1_x         <= '0;
         s1_y         <= '0;
         s1_color     <= '0;
         vsync_d      <= 1'b0;
      end else begin
         s1_valid     <= rgb_valid_in;
         s1_in_bounds <= (x_in < 11'(H_RES)) && (y_in < 11'(V_RES));
         s1_last      <= (x_in == 11'(H_RES - 1)) && (y_in == 11'(V_RES - 1));
         s1_x         <= PIX_W'(x_in);
         s1_y         <= PIX_W'(y_in);
         s1_color     <= block_visible_in ? {r_in, g_in, b_in} : BG_COLOR;
         vsync_d      <= disp_vsync_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= FILL;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      swap       = 1'b0;
      vsync_rise = disp_vsync_in & ~vsync_d;
      accept     = s1_valid && s1_in_bounds && (state == FILL);
      drop       = s1_valid && !accept;
      pix_index  = s1_y * PIX_W'(H_RES) + s1_x;
      case (state)
         FILL: begin
            // A vsync edge coinciding with the last write is ignored; the next edge swaps
            if (accept && s1_last) state_next = WAIT_SWAP;
         end
         WAIT_SWAP: begin
            if (vsync_rise) begin
               state_next = FILL;
               swap       = 1'b1;
            end
         end
         default: state_next = FILL;
      endcase
   end

   // Stage 2: write port, buffer swap and drop accounting
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_addr_out    <= '0;
         wr_data_out    <= '0;
         wr_en_out      <= 1'b0;
         front_buf_out  <= 1'b0;
         back_buf       <= 1'b1;
         frame_done_out <= 1'b0;
         overrun_out    <= 1'b0;
         drop_count_out <= '0;
      end else begin
         wr_en_out      <= accept;
         frame_done_out <= swap;
         if (accept) begin
            wr_addr_out <= {back_buf, pix_index};
            wr_data_out <= s1_color;
         end
         if (swap) begin
            front_buf_out <= ~front_buf_out;
            back_buf      <= ~back_buf;
         end
         if (drop) begin
            if (drop_count_out != 16'hFFFF) drop_count_out <= drop_count_out + 16'd1;
            if (state == WAIT_SWAP) overrun_out <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pixel_framebuffer_writer.sv
// Scoreboard bench for pixel_framebuffer_writer: a frame-level reference model queues
// expected writes and swap pulses; a negedge monitor pops and compares them.
module tb_pixel_framebuffer_writer;

   localparam int H = 320;
   localparam int V = 180;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [10:0] x_in = '0, y_in = '0;
   logic        block_visible_in = 1'b0;
   logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
   logic        rgb_valid_in = 1'b0;
   logic        disp_vsync_in = 1'b0;
   logic [16:0] wr_addr_out;
   logic [11:0] wr_data_out;
   logic        wr_en_out, front_buf_out, frame_done_out, overrun_out;
   logic [15:0] drop_count_out;

   pixel_framebuffer_writer #(.H_RES(H), .V_RES(V), .BG_COLOR(12'h000)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
      .block_visible_in(block_visible_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .rgb_valid_in(rgb_valid_in), .disp_vsync_in(disp_vsync_in),
      .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_en_out(wr_en_out),
      .front_buf_out(front_buf_out), .frame_done_out(frame_done_out),
      .overrun_out(overrun_out), .drop_count_out(drop_count_out)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [16:0] addr;
      logic [11:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  fd_q[$];
   int  checks = 0;
   int  errors = 0;

   // frame-level reference state
   bit m_wait, m_front, m_overrun;
   int m_drops;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic void model_pixel(input int c, input int x, input int y, input bit vis,
                                       input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
      wr_t w;
      if (x >= H || y >= V || m_wait) begin
         if (m_drops < 65535) m_drops++;
         if (m_wait) m_overrun = 1'b1;
      end else begin
         w.cyc  = c + 2;
         w.addr = {~m_front, 16'(y * H + x)};
         w.data = vis ? {r, g, b} : 12'h000;
         exp_q.push_back(w);
         if (x == H - 1 && y == V - 1) m_wait = 1'b1;
      end
   endfunction

   function automatic void model_vsync(input int c);
      if (m_wait) begin
         m_wait  = 1'b0;
         m_front = ~m_front;
         fd_q.push_back(c + 1);
      end
   endfunction

   function automatic void model_reset(input int c);
      while (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
      while (fd_q.size() > 0 && fd_q[$] > c) void'(fd_q.pop_back());
      m_wait = 1'b0; m_front = 1'b0; m_overrun = 1'b0; m_drops = 0;
   endfunction

   always @(negedge clk_in) begin
      wr_t w;
      int  f;
      if (wr_en_out) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected (cycle %0d)",
                     wr_addr_out, wr_data_out, cyc);
         end else begin
            w = exp_q.pop_front();
            chk("write_cycle", cyc, w.cyc);
            chk("write_addr", 32'(wr_addr_out), 32'(w.addr));
            chk("write_data", 32'(wr_data_out), 32'(w.data));
         end
      end
      if (frame_done_out) begin
         checks++;
         if (fd_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame_done: got pulse, none expected (cycle %0d)", cyc);
         end else begin
            f = fd_q.pop_front();
            chk("frame_done_cycle", cyc, f);
         end
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic issue(input int x, input int y, input bit vis,
                        input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
      x_in = 11'(x); y_in = 11'(y);
      block_visible_in = vis; r_in = r; g_in = g; b_in = b;
      rgb_valid_in = 1'b1;
      model_pixel(cyc, x, y, vis, r, g, b);
      step();
      rgb_valid_in = 1'b0;
   endtask

   task automatic vsync_pulse();
      idle(2);
      disp_vsync_in = 1'b1;
      model_vsync(cyc);
      step();
      disp_vsync_in = 1'b0;
      idle(3);
   endtask

   task automatic check_status(input string tag);
      idle(3);
      chk({tag, "_front_buf"}, 32'(front_buf_out), 32'(m_front));
      chk({tag, "_overrun"}, 32'(overrun_out), 32'(m_overrun));
      chk({tag, "_drop_count"}, 32'(drop_count_out), 32'(m_drops));
      chk({tag, "_writes_pending"}, exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wr_en"}, 32'(wr_en_out), 0);
      chk({tag, "_wr_addr"}, 32'(wr_addr_out), 0);
      chk({tag, "_wr_data"}, 32'(wr_data_out), 0);
      chk({tag, "_front_buf"}, 32'(front_buf_out), 0);
      chk({tag, "_frame_done"}, 32'(frame_done_out), 0);
      chk({tag, "_overrun"}, 32'(overrun_out), 0);
      chk({tag, "_drop_count"}, 32'(drop_count_out), 0);
   endtask

   initial begin
      int r;
      model_reset(0);
      idle(3);
      rst_in = 1'b0;
      check_reset_outputs("reset");

      // full raster, constant colour: every write lands in buffer 1
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++)
            issue(x, y, 1'b1, 4'h5, 4'hA, 4'h3);
      check_status("full_frame");

      vsync_pulse();
      check_status("first_swap");
      issue(0, 0, 1'b1, 4'h1, 4'h2, 4'h3);

      issue(320, 0, 1'b1, 4'hF, 4'hF, 4'hF);
      issue(0, 180, 1'b1, 4'hF, 4'hF, 4'hF);
      check_status("out_of_bounds");

      issue(7, 2, 1'b1, 4'h9, 4'h8, 4'h7);
      issue(319, 179, 1'b0, 4'hC, 4'hC, 4'hC);
      for (int i = 0; i < 3; i++) issue(i, 0, 1'b1, 4'h4, 4'h4, 4'h4);
      check_status("overrun");
      vsync_pulse();
      check_status("second_swap");

      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3) vsync_pulse();
         else if (r < 7) issue(H - 1, V - 1, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
         else issue(int'($urandom_range(0, 329)), int'($urandom_range(0, 189)), 1'($urandom),
                    4'($urandom), 4'($urandom), 4'($urandom));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      vsync_pulse();
      check_status("random");

      // last pixel's write and a vsync rising edge are evaluated on the same clock edge:
      // the edge arrives while still filling, so it is applied to the model first
      x_in = 11'(H - 1); y_in = 11'(V - 1);
      block_visible_in = 1'b1; r_in = 4'h6; g_in = 4'h6; b_in = 4'h6;
      rgb_valid_in = 1'b1;
      model_vsync(cyc + 1);
      model_pixel(cyc, H - 1, V - 1, 1'b1, 4'h6, 4'h6, 4'h6);
      step();
      rgb_valid_in = 1'b0;
      disp_vsync_in = 1'b1;
      step();
      disp_vsync_in = 1'b0;
      check_status("simultaneous_no_swap");
      vsync_pulse();
      check_status("simultaneous_next_swap");

      for (int i = 0; i < 6; i++) issue(i, 10, 1'b1, 4'h2, 4'h4, 4'h8);
      rst_in = 1'b1;
      model_reset(cyc);
      step();
      check_reset_outputs("mid_reset");
      rst_in = 1'b0;
      issue(5, 5, 1'b1, 4'h1, 4'h1, 4'h1);
      check_status("after_reset");

      idle(5);
      chk("final_writes_pending", exp_q.size(), 0);
      chk("final_frame_done_pending", fd_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
